// File: rtl/lfcpnx_irq_pkg.sv
// Shared constants and types for the lfcpnx interrupt controller.
package lfcpnx_irq_pkg;

  localparam int unsigned N_IRQ_MAX = 32;

  typedef logic [N_IRQ_MAX-1:0] irq_vec_t;

  localparam int unsigned IRQ_TIMER    = 4;
  localparam int unsigned IRQ_SLOWTICK = 5;

endpackage

// File: rtl/lfcpnx_irq_bit.sv
// One interrupt source: input staging, edge/eoi detection, pending and overflow state.
// Define IRQ_SYNC_EN to put a 2-flop synchronizer in front of the source register.
module lfcpnx_irq_bit
  import lfcpnx_irq_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic irq_src,
  input  logic irq_level,
  input  logic eoi,
  input  logic ovf_clr,
  output logic pending,
  output logic overflow
);

  logic r_src_q;
  logic r_src_p;
  logic r_eoi_p;
  logic r_level_p;
  logic r_pending;
  logic r_overflow;
  logic w_src_in;
  logic w_rise;
  logic w_eoi_rise;
  logic w_mode_chg;
  logic w_pending_n;
  logic w_overflow_n;

`ifdef IRQ_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  // Two-stage synchronizer for sources asynchronous to clk.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= irq_src;
      r_sync2 <= r_sync1;
    end
  end

  assign w_src_in = r_sync2;
`else
  assign w_src_in = irq_src;
`endif

  assign w_rise     = r_src_q & ~r_src_p;
  assign w_eoi_rise = eoi & ~r_eoi_p;
  assign w_mode_chg = irq_level ^ r_level_p;

  // A new edge beats a simultaneous eoi, so a re-raised source is never lost.
  always_comb begin
    w_pending_n  = r_pending;
    w_overflow_n = r_overflow;
    if (w_mode_chg) begin
      w_pending_n = 1'b0;
    end else if (irq_level) begin
      w_pending_n = r_src_q;
    end else if (w_rise) begin
      w_pending_n = 1'b1;
    end else if (w_eoi_rise) begin
      w_pending_n = 1'b0;
    end
    if (!irq_level && w_rise && r_pending && !w_eoi_rise) begin
      w_overflow_n = 1'b1;
    end else if (ovf_clr) begin
      w_overflow_n = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_src_q    <= 1'b0;
      r_src_p    <= 1'b0;
      r_eoi_p    <= 1'b0;
      r_level_p  <= 1'b0;
      r_pending  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_src_q    <= w_src_in;
      r_src_p    <= r_src_q;
      r_eoi_p    <= eoi;
      r_level_p  <= irq_level;
      r_pending  <= w_pending_n;
      r_overflow <= w_overflow_n;
    end
  end

  assign pending  = r_pending;
  assign overflow = r_overflow;

endmodule

// File: rtl/lfcpnx_irq_ctrl.sv
// Interrupt controller for picosoc: per-source pending/overflow tracking and a registered irq vector.
// Define IRQ_SYNC_EN to synchronize asynchronous sources (adds two cycles of latency).
module lfcpnx_irq_ctrl
  import lfcpnx_irq_pkg::*;
#(
  parameter int unsigned N_IRQ = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [N_IRQ-1:0] irq_src,
  input  logic [N_IRQ-1:0] irq_en,
  input  logic [N_IRQ-1:0] irq_level,
  input  logic [N_IRQ-1:0] eoi,
  input  logic [N_IRQ-1:0] ovf_clr,
  output logic [N_IRQ-1:0] irq,
  output logic [N_IRQ-1:0] pending,
  output logic [N_IRQ-1:0] overflow
);

  logic [N_IRQ-1:0] w_pending;
  logic [N_IRQ-1:0] w_overflow;
  logic [N_IRQ-1:0] r_irq;
  irq_vec_t         w_req;

  for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_bit
    lfcpnx_irq_bit u_bit (
      .clk       (clk),
      .resetn    (resetn),
      .irq_src   (irq_src[gi]),
      .irq_level (irq_level[gi]),
      .eoi       (eoi[gi]),
      .ovf_clr   (ovf_clr[gi]),
      .pending   (w_pending[gi]),
      .overflow  (w_overflow[gi])
    );
  end

  // Zero-extended to the full picosoc width so nonexistent sources read as 0.
  assign w_req = irq_vec_t'(w_pending & irq_en);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_irq <= '0;
    end else begin
      r_irq <= w_req[N_IRQ-1:0];
    end
  end

  assign irq      = r_irq;
  assign pending  = w_pending;
  assign overflow = w_overflow;

endmodule

// File: tb/tb_lfcpnx_irq_ctrl.sv
// Scoreboard bench for lfcpnx_irq_ctrl: vector-level reference model feeds an expectation queue.
module tb_lfcpnx_irq_ctrl;
  import lfcpnx_irq_pkg::*;

  localparam int unsigned N = 32;
`ifdef IRQ_SYNC_EN
  localparam int unsigned SD = 3;
`else
  localparam int unsigned SD = 1;
`endif
  localparam int unsigned SX = SD - 1;
  localparam logic [N-1:0] B4 = N'(1) << IRQ_TIMER;
  localparam logic [N-1:0] B5 = N'(1) << IRQ_SLOWTICK;
  localparam logic [N-1:0] B6 = N'(1) << 6;

  typedef struct packed {
    logic [N-1:0] irq;
    logic [N-1:0] pend;
    logic [N-1:0] ovf;
  } exp_t;

  logic         clk;
  logic         resetn;
  logic [N-1:0] irq_src, irq_en, irq_level, eoi, ovf_clr;
  logic [N-1:0] irq, pending, overflow;

  exp_t         q[$];
  int           n_checks = 0;
  int           n_err    = 0;

  // Reference state: source delay line, previous-sample copies, and architectural outputs.
  logic [N-1:0] m_pipe[SD];
  logic [N-1:0] m_sp, m_ep, m_lvp, m_pend, m_ovf, m_irq;

  lfcpnx_irq_ctrl #(.N_IRQ(N)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .irq_src   (irq_src),
    .irq_en    (irq_en),
    .irq_level (irq_level),
    .eoi       (eoi),
    .ovf_clr   (ovf_clr),
    .irq       (irq),
    .pending   (pending),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic model_step();
    logic [N-1:0] rise, erise, chg, sq;
    if (!resetn) begin
      for (int k = 0; k < int'(SD); k++) m_pipe[k] = '0;
      m_sp = '0; m_ep = '0; m_lvp = '0; m_pend = '0; m_ovf = '0; m_irq = '0;
    end else begin
      sq    = m_pipe[SD-1];
      rise  = sq & ~m_sp;
      erise = eoi & ~m_ep;
      chg   = irq_level ^ m_lvp;
      m_irq = m_pend & irq_en;
      m_ovf = (~irq_level & rise & m_pend & ~erise) | (m_ovf & ~ovf_clr);
      m_pend = ~chg & ((irq_level & sq) | (~irq_level & (rise | (m_pend & ~erise))));
      m_sp  = sq;
      for (int k = int'(SD) - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
      m_pipe[0] = irq_src;
      m_ep  = eoi;
      m_lvp = irq_level;
    end
    q.push_back('{irq: m_irq, pend: m_pend, ovf: m_ovf});
  endtask

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      model_step();
      @(negedge clk);
    end
  endtask

  task automatic pulse(input logic [N-1:0] mask);
    irq_src = irq_src | mask;
    cyc(1);
    irq_src = irq_src & ~mask;
    cyc(int'(SX));
  endtask

  // Monitor: every edge produces one expected output triple.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
        chk("sb_empty", N'(1), N'(0));
      end else begin
        e = q.pop_front();
        chk("sb_irq", irq, e.irq);
        chk("sb_pending", pending, e.pend);
        chk("sb_overflow", overflow, e.ovf);
      end
    end
  end

  initial begin
    int           lvl_cnt, c4, c5;
    logic [N-1:0] prev, hist[5];
    logic [15:0]  cv;

    resetn = 1'b0; irq_src = B4; irq_en = B4; irq_level = '0; eoi = '0; ovf_clr = '0;
    cyc(3);
    chk("rst_irq", irq, '0);
    chk("rst_pending", pending, '0);
    chk("rst_overflow", overflow, '0);
    resetn = 1'b1;
    cyc(1 + int'(SX));
    chk("rel_pend_early", pending, '0);
    cyc(1);
    chk("rel_pend", pending, B4);
    irq_src = '0;
    cyc(2);
    eoi = B4; cyc(1); eoi = '0; cyc(3);
    chk("rel_cleared", pending, '0);

    // Single edge pulse, then eoi
    pulse(B4);
    cyc(1);
    chk("pulse_irq_lat1", irq, '0);
    chk("pulse_pend", pending, B4);
    cyc(1);
    chk("pulse_irq", irq, B4);
    cyc(6);
    chk("pulse_hold", irq, B4);
    eoi = B4;
    cyc(1);
    chk("eoi_pend", pending, '0);
    cyc(1);
    chk("eoi_irq", irq, '0);
    cyc(2); eoi = '0; cyc(2);

    // Edge coinciding with eoi rise on an already-pending source
    irq_en = B4 | B5;
    pulse(B5);
    cyc(4);
    irq_src = B5; cyc(1); irq_src = '0; cyc(int'(SX));
    eoi = B5; cyc(1); eoi = '0;
    cyc(2);
    chk("coll_pend", pending & B5, B5);
    chk("coll_ovf", overflow, '0);

    // Overflow from a second unacknowledged edge, then clear
    pulse(B4);
    cyc(9);
    pulse(B4);
    cyc(2);
    chk("ovf_set", overflow, B4);
    ovf_clr = B4; cyc(1); ovf_clr = '0;
    chk("ovf_clr", overflow, '0);

    // Asynchronous reset discards state immediately
    chk("pre_rst_pend", pending, B4 | B5);
    pulse(B4);
    cyc(2);
    chk("pre_rst_ovf", overflow, B4);
    resetn = 1'b0;
    #1;
    chk("async_irq", irq, '0);
    chk("async_pending", pending, '0);
    chk("async_overflow", overflow, '0);
    cyc(2);
    resetn = 1'b1;
    cyc(3);

    // Level mode: irq mirrors the source, eoi ignored
    irq_level = B6; irq_en = B6;
    cyc(3);
    lvl_cnt = 0;
    irq_src = B6;
    for (int i = 0; i < 30; i++) begin
      if (i == 20) irq_src = '0;
      eoi = N'($urandom) & B6;
      cyc(1);
      if ((irq & B6) != '0) lvl_cnt++;
    end
    chk("lvl_cycles", N'(lvl_cnt), N'(20));
    chk("lvl_ovf", overflow, '0);
    eoi = '0; irq_level = '0;
    cyc(3);

    // Periodic sources from a free-running counter with eoi echoed 5 cycles later
    resetn = 1'b0; irq_src = '0; irq_en = B4 | B5; eoi = '0;
    cyc(2);
    resetn = 1'b1;
    cyc(2);
    for (int k = 0; k < 5; k++) hist[k] = '0;
    c4 = 0; c5 = 0; prev = irq;
    for (int c = 0; c < 65536 + 20; c++) begin
      irq_src = '0;
      if (c < 65536) begin
        cv = 16'(c);
        irq_src[IRQ_TIMER]    = &cv[12:0];
        irq_src[IRQ_SLOWTICK] = &cv;
      end
      eoi = hist[4];
      cyc(1);
      for (int k = 4; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = m_irq & (B4 | B5);
      if (irq[IRQ_TIMER] && !prev[IRQ_TIMER]) c4++;
      if (irq[IRQ_SLOWTICK] && !prev[IRQ_SLOWTICK]) c5++;
      prev = irq;
    end
    chk("per_irq4", N'(c4), N'(8));
    chk("per_irq5", N'(c5), N'(1));
    chk("per_ovf", overflow, '0);

    // Randomized traffic
    resetn = 1'b0; irq_src = '0; eoi = '0; irq_level = '0;
    cyc(2);
    resetn = 1'b1;
    irq_en = N'($urandom);
    for (int i = 0; i < 2000; i++) begin
      irq_src = irq_src ^ (N'($urandom) & N'($urandom) & N'($urandom));
      eoi     = eoi ^ (N'($urandom) & N'($urandom));
      ovf_clr = N'($urandom) & N'($urandom) & N'($urandom) & N'($urandom);
      if ($urandom_range(0, 49) == 0) irq_en = N'($urandom);
      if ($urandom_range(0, 99) == 0) irq_level = irq_level ^ (N'(1) << $urandom_range(0, N - 1));
      resetn = ($urandom_range(0, 299) != 0);
      cyc(1);
    end
    resetn = 1'b1;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/lfcpnx_irq_ctrl.md
LFCPNX_IRQ_CTRL -- requirements
Module: lfcpnx_irq_ctrl

Interface
REQ-001 Parameter N_IRQ, default 32: number of interrupt sources, range 1..32.
REQ-002 clk  in  1  single clock for all logic, same clock as picosoc clk.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 irq_src  in  N_IRQ  raw interrupt sources from peripherals and test generators (pulses or levels).
REQ-005 irq_en  in  N_IRQ  per-source enable; quasi-static.
REQ-006 irq_level  in  N_IRQ  per-source mode: 1 = level, 0 = rising-edge latched.
REQ-007 eoi  in  N_IRQ  end-of-interrupt vector driven by picosoc eoi.
REQ-008 ovf_clr  in  N_IRQ  per-bit single-cycle pulse that clears the overflow flags.
REQ-009 irq  out  N_IRQ  registered request vector driving picosoc irq.
REQ-010 pending  out  N_IRQ  raw latched-pending state before enable masking.
REQ-011 overflow  out  N_IRQ  sticky per-source "edge lost" flags.

Function
REQ-012 src_q SHALL be irq_src registered once, or via the 2-flop synchronizer when IRQ_SYNC_EN is defined; src_p SHALL be src_q delayed one cycle.
REQ-013 Edge mode: rise[i] = src_q[i] & ~src_p[i]; on rise[i], pending[i] SHALL be set on the next clk edge.
REQ-014 eoi_rise[i] = eoi[i] & ~eoi_p[i]; on eoi_rise[i], pending[i] SHALL be cleared on the next clk edge.
REQ-015 If rise[i] and eoi_rise[i] occur in the same cycle, the set SHALL win, so pending[i] stays 1.
REQ-016 A level-held eoi SHALL NOT clear a pending bit that is re-set while eoi stays high.
REQ-017 If rise[i] occurs while pending[i]=1 and there is no eoi_rise[i] that cycle, overflow[i] SHALL be set.
REQ-018 overflow[i] SHALL clear when ovf_clr[i]=1; if set and clear coincide, set SHALL win.
REQ-019 Level mode: pending[i] SHALL equal src_q[i] each cycle; eoi[i] is ignored; overflow[i] is never set.
REQ-020 irq[i] SHALL equal the registered value of pending[i] & irq_en[i].
REQ-021 Latency, edge mode: irq_src rise at clock edge t gives irq high after edge t+2; add 2 cycles when IRQ_SYNC_EN is defined.
REQ-022 Disabling a source (irq_en[i]=0) SHALL drop irq[i] the next cycle and SHALL NOT clear pending[i].
REQ-023 Changing irq_level[i] SHALL clear pending[i] in the same cycle.
REQ-024 Bits at index N_IRQ..31 do not exist; the top level ties the unused picosoc irq bits to 0.

Reset
REQ-025 While resetn=0: irq, pending, overflow, src_q, src_p, eoi_p and the synchronizer flops SHALL be 0.
REQ-026 Because src_p resets to 0, a source already high when reset is released SHALL register one edge.
REQ-027 A reset asserted mid-operation SHALL discard all pending and overflow state immediately (asynchronously).

Configuration
REQ-028 Macro IRQ_SYNC_EN defined: each irq_src bit passes through a 2-flop synchronizer before edge detection, for asynchronous sources such as board buttons.
REQ-029 Macro IRQ_SYNC_EN undefined: a single register stage is used; all sources must be synchronous to clk.

Structure
REQ-030 Package lfcpnx_irq_pkg SHALL hold N_IRQ_MAX=32 and typedef irq_vec_t (logic [31:0]).
REQ-031 The package SHALL hold the IRQ index constants: IRQ_TIMER=4, IRQ_SLOWTICK=5.
REQ-032 Sub-module lfcpnx_irq_bit SHALL implement one source: edge detect, eoi edge, pending, overflow and the level mux.
REQ-033 lfcpnx_irq_ctrl SHALL instantiate N_IRQ copies of lfcpnx_irq_bit in a generate loop and register irq.

Verification
REQ-034 Edge mode, single pulse: irq_en=0x10, irq_src[4] pulsed 1 cycle -> irq=0x10 two cycles later; stays set; eoi[4] rises -> irq=0 after 2 cycles.
REQ-035 Edge/eoi collision: irq_src[5] rise in the same cycle as eoi[5] rise -> pending[5] stays 1 and overflow[5] stays 0.
REQ-036 Overflow: two irq_src[4] pulses 10 cycles apart with no eoi -> overflow=0x10; then ovf_clr=0x10 pulse -> overflow=0.
REQ-037 Level mode: irq_level[6]=1, irq_en[6]=1, irq_src[6] high for 20 cycles -> irq[6] high for exactly 20 cycles, delayed by 2; eoi has no effect.
REQ-038 Reset mid-operation: pending=0x30, resetn pulled low -> irq, pending and overflow all 0 immediately.
REQ-038 (cont.) Reset release with irq_src[4]=1 -> pending[4]=1 after 2 cycles.
REQ-039 Periodic: free-running 16-bit counter drives src[4]=&cnt[12:0] and src[5]=&cnt[15:0], with eoi echoed 5 cycles after each irq.
REQ-039 (cont.) Expected result: over 65536 cycles, 8 irq[4] and 1 irq[5] assertions, and overflow stays 0.
